// File: rtl/counter_64_axi_pkg.sv
// counter_64_axi shared definitions
// register offsets, response codes, decode and byte-merge helpers
package counter_64_axi_pkg;

   localparam logic [11:0] ADDR_COUNT  = 12'h000;
   localparam logic [11:0] ADDR_CTRL   = 12'h008;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      SEL_COUNT,
      SEL_CTRL,
      SEL_NONE
   } reg_sel_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ACK,
      W_RESP
   } wr_state_e;

   // only address bits [4:3] select a register
   function automatic reg_sel_e decode(input logic [1:0] a);
      reg_sel_e s;
      s = SEL_NONE;
      unique case (1'b1)
         (a == ADDR_COUNT[4:3]): s = SEL_COUNT;
         (a == ADDR_CTRL[4:3]):  s = SEL_CTRL;
         default:                s = SEL_NONE;
      endcase
      return s;
   endfunction

   function automatic logic [63:0] apply_wstrb(
      input logic [63:0] cur,
      input logic [63:0] wd,
      input logic [7:0]  strb
   );
      logic [63:0] r;
      r = cur;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) r[i*8 +: 8] = wd[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/counter_64_axi_axil_slave_if.sv
// AXI4-Lite slave handshake FSMs for counter_64_axi
// turns AR/R and AW/W/B traffic into register strobes
module axil_slave_if
   import counter_64_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [ADDR_WIDTH-1:0] araddr,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [63:0]           rdata,
   output logic [1:0]            rresp,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic                  wvalid,
   output logic                  wready,
   input  logic [63:0]           wdata,
   input  logic [7:0]            wstrb,
   output logic                  bvalid,
   input  logic                  bready,
   output logic [1:0]            bresp,
   output logic [1:0]            rd_addr,
   input  logic [63:0]           rd_data,
   input  logic                  rd_err,
   output logic                  wr_en,
   output logic [1:0]            wr_addr,
   output logic [63:0]           wr_data,
   output logic [7:0]            wr_strb,
   input  logic                  wr_err
);

   rd_state_e rd_st;
   wr_state_e wr_st;
   logic      wr_ack;
   logic      unused_addr;

   assign unused_addr = ^{araddr[ADDR_WIDTH-1:5], araddr[2:0],
                          awaddr[ADDR_WIDTH-1:5], awaddr[2:0]};

   assign rd_addr = araddr[4:3];
   assign wr_addr = awaddr[4:3];
   assign wr_data = wdata;
   assign wr_strb = wstrb;
   assign awready = wr_ack;
   assign wready  = wr_ack;
   assign wr_en   = wr_ack & awvalid & wvalid;

   // read channel: capture the register value on AR handshake, hold until R
   always_ff @(posedge aclk) begin
      if (areset) begin
         rd_st   <= R_IDLE;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
      end else begin
         case (rd_st)
            R_IDLE: begin
               if (arvalid && arready) begin
                  arready <= 1'b0;
                  rvalid  <= 1'b1;
                  rdata   <= rd_data;
                  rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                  rd_st   <= R_RESP;
               end else begin
                  arready <= 1'b1;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rvalid  <= 1'b0;
                  arready <= 1'b1;
                  rd_st   <= R_IDLE;
               end
            end
            default: rd_st <= R_IDLE;
         endcase
      end
   end

   // write channel: one-cycle joint AW/W accept, then hold B until bready
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_st  <= W_IDLE;
         wr_ack <= 1'b0;
         bvalid <= 1'b0;
         bresp  <= RESP_OKAY;
      end else begin
         case (wr_st)
            W_IDLE: begin
               if (awvalid && wvalid) begin
                  wr_ack <= 1'b1;
                  wr_st  <= W_ACK;
               end
            end
            W_ACK: begin
               if (awvalid && wvalid) begin
                  wr_ack <= 1'b0;
                  bvalid <= 1'b1;
                  bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                  wr_st  <= W_RESP;
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  wr_st  <= W_IDLE;
               end
            end
            default: wr_st <= W_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/counter_64_axi.sv
// counter_64_axi: free-running 64-bit timestamp counter
// readable, loadable and gateable over AXI4-Lite
module counter_64_axi
   import counter_64_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_areset,
   output logic [DATA_WIDTH-1:0]   cnt,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]              s_axi_arprot,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]              s_axi_awprot,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   output logic [1:0]              s_axi_bresp
);

   logic [1:0]  rd_addr;
   logic [1:0]  wr_addr;
   logic [63:0] rd_data;
   logic [63:0] wr_data;
   logic [7:0]  wr_strb;
   logic        rd_err;
   logic        wr_err;
   logic        wr_en;
   logic        en;
   reg_sel_e    rd_sel;
   reg_sel_e    wr_sel;
   logic        unused_prot;

   assign unused_prot = ^{s_axi_arprot, s_axi_awprot};

   assign rd_sel = decode(rd_addr);
   assign wr_sel = decode(wr_addr);
   assign wr_err = (wr_sel == SEL_NONE);

   axil_slave_if #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_if (
      .aclk    (s_axi_aclk),
      .areset  (s_axi_areset),
      .arvalid (s_axi_arvalid),
      .arready (s_axi_arready),
      .araddr  (s_axi_araddr),
      .rvalid  (s_axi_rvalid),
      .rready  (s_axi_rready),
      .rdata   (s_axi_rdata),
      .rresp   (s_axi_rresp),
      .awvalid (s_axi_awvalid),
      .awready (s_axi_awready),
      .awaddr  (s_axi_awaddr),
      .wvalid  (s_axi_wvalid),
      .wready  (s_axi_wready),
      .wdata   (s_axi_wdata),
      .wstrb   (s_axi_wstrb),
      .bvalid  (s_axi_bvalid),
      .bready  (s_axi_bready),
      .bresp   (s_axi_bresp),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rd_err  (rd_err),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .wr_err  (wr_err)
   );

   // register read mux; unmapped reads return zero with an error flag
   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      case (rd_sel)
         SEL_COUNT: rd_data = cnt;
         SEL_CTRL:  rd_data = {63'd0, en};
         default:   rd_err  = 1'b1;
      endcase
   end

   // counter and enable: a bus load wins over the increment
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         cnt <= '0;
         en  <= 1'b1;
      end else begin
         if (wr_en && wr_sel == SEL_COUNT)
            cnt <= apply_wstrb(cnt, wr_data, wr_strb);
         else if (en)
            cnt <= cnt + 64'd1;
         if (wr_en && wr_sel == SEL_CTRL && wr_strb[0])
            en <= wr_data[0];
      end
   end

endmodule

// File: tb/tb_counter_64_axi.sv
// testbench for counter_64_axi
// directed steps plus random traffic against a timestamp model
module tb_counter_64_axi;

   logic        clk = 1'b0;
   logic        areset;
   logic [63:0] cnt;
   logic        arvalid, arready;
   logic [11:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid, rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        awvalid, awready;
   logic [11:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid, wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        bvalid, bready;
   logic [1:0]  bresp;

   int total = 0;
   int bad = 0;

   longint unsigned cyc = 0;
   logic [63:0]     m_base;
   longint unsigned m_c0;
   bit              m_en;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   counter_64_axi dut (
      .s_axi_aclk    (clk),
      .s_axi_areset  (areset),
      .cnt           (cnt),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_araddr  (araddr),
      .s_axi_arprot  (arprot),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_awaddr  (awaddr),
      .s_axi_awprot  (awprot),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_bresp   (bresp)
   );

   // timestamp model: value = base + elapsed cycles while enabled
   function automatic logic [63:0] m_now();
      return m_base + (m_en ? 64'(cyc - m_c0) : 64'd0);
   endfunction

   task automatic m_reset();
      m_base = '0;
      m_en   = 1'b1;
      m_c0   = cyc;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_start(input logic [11:0] a, output logic [63:0] ed,
                           output logic [1:0] er,
                           output longint unsigned hs);
      int n;
      araddr  = a;
      arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin
         tick();
         n++;
      end
      chk("ar_wait", arready, 1);
      case (a[4:3])
         2'd0:    begin ed = m_now();       er = 2'b00; end
         2'd1:    begin ed = {63'd0, m_en}; er = 2'b00; end
         default: begin ed = '0;            er = 2'b10; end
      endcase
      hs = cyc;
      tick();
      arvalid = 1'b0;
      chk("rvalid_rise", rvalid, 1);
   endtask

   task automatic rd_finish(input int hold, output logic [63:0] d,
                            output logic [1:0] r);
      int n;
      repeat (hold) tick();
      rready = 1'b1;
      n = 0;
      while (!rvalid && n < 50) begin
         tick();
         n++;
      end
      d = rdata;
      r = rresp;
      tick();
      rready = 1'b0;
      chk("arready_back", arready, 1);
   endtask

   task automatic do_read(input logic [11:0] a, input int hold,
                          output logic [63:0] d);
      logic [63:0] ed;
      logic [1:0]  er, r;
      longint unsigned hs;
      rd_start(a, ed, er, hs);
      rd_finish(hold, d, r);
      chk("rdata", d, ed);
      chk("rresp", r, er);
   endtask

   task automatic wr_start(input logic [11:0] a, input logic [63:0] d,
                           input logic [7:0] s);
      int n;
      logic [63:0] cur, mask;
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      n = 0;
      while (!(awready && wready) && n < 50) begin
         tick();
         n++;
      end
      chk("aw_w_wait", {awready, wready}, 2'b11);
      cur = m_now();
      for (int i = 0; i < 8; i++) mask[i*8 +: 8] = {8{s[i]}};
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      if (a[4:3] == 2'd0) begin
         m_base = (cur & ~mask) | (d & mask);
         m_c0   = cyc;
      end else if (a[4:3] == 2'd1 && s[0]) begin
         m_base = cur + (m_en ? 64'd1 : 64'd0);
         m_en   = d[0];
         m_c0   = cyc;
      end
      chk("bvalid_rise", bvalid, 1);
   endtask

   task automatic wr_finish(input int hold, output logic [1:0] r);
      int n;
      repeat (hold) tick();
      bready = 1'b1;
      n = 0;
      while (!bvalid && n < 50) begin
         tick();
         n++;
      end
      r = bresp;
      tick();
      bready = 1'b0;
      chk("bvalid_fall", bvalid, 0);
   endtask

   task automatic do_write(input logic [11:0] a, input logic [63:0] d,
                           input logic [7:0] s, input int hold);
      logic [1:0] r;
      wr_start(a, d, s);
      wr_finish(hold, r);
      chk("bresp", r, (a[4:3] >= 2'd2) ? 2'b10 : 2'b00);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ed, d, d1, d2, d3, prev_d;
      logic [1:0]  er, r;
      longint unsigned hs, prev_hs, st;
      int op;

      areset = 1'b1;
      arvalid = 0; araddr = 0; arprot = 0; rready = 0;
      awvalid = 0; awaddr = 0; awprot = 0;
      wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
      m_reset();

      repeat (10) tick();
      chk("rst_cnt", cnt, 0);
      chk("rst_arready", arready, 0);
      chk("rst_awready", {awready, wready}, 0);
      chk("rst_valids", {rvalid, bvalid}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_resps", {rresp, bresp}, 0);

      areset = 1'b0;
      m_reset();
      chk("rel_cnt0", cnt, 0);
      chk("rel_arready0", arready, 0);
      tick();
      chk("rel_arready1", arready, 1);
      chk("rel_rvalid", rvalid, 0);
      chk("rel_cnt1", cnt, 1);
      repeat (4) tick();
      chk("rel_cnt5", cnt, 5);

      prev_d = '0;
      prev_hs = 0;
      for (int i = 0; i < 10; i++) begin
         st = cyc;
         rd_start(12'h000, ed, er, hs);
         rd_finish(0, d, r);
         chk("seq_rdata", d, ed);
         chk("seq_rresp", r, 0);
         if (i > 0) chk("seq_delta", d - prev_d, 64'(hs - prev_hs));
         prev_d = d;
         prev_hs = hs;
         while (cyc < st + 10) tick();
      end

      rd_start(12'h000, ed, er, hs);
      for (int i = 0; i < 20; i++) begin
         chk("stall_rvalid", rvalid, 1);
         chk("stall_rdata", rdata, ed);
         chk("stall_rresp", rresp, 0);
         chk("stall_arready", arready, 0);
         tick();
      end
      rd_finish(0, d, r);
      chk("stall_final", d, ed);

      wr_start(12'h000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
      chk("wrap_fe", cnt, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      chk("wrap_ff", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      chk("wrap_0", cnt, 64'h0);
      chk("bvalid_held", bvalid, 1);
      wr_finish(0, r);
      chk("wrap_bresp", r, 0);
      do_read(12'h000, 1, d);

      do_write(12'h008, 64'h0, 8'hFF, 0);
      do_read(12'h000, 0, d1);
      repeat (3) tick();
      do_read(12'h000, 2, d2);
      chk("dis_hold", d2, d1);
      do_write(12'h000, 64'h1234, 8'h01, 0);
      do_read(12'h000, 0, d3);
      chk("dis_byte0", d3, {d2[63:8], 8'h34});
      do_read(12'h008, 0, d);
      chk("ctrl_off", d, 0);
      do_write(12'h008, 64'h1, 8'hFF, 1);
      do_read(12'h000, 0, d1);
      do_read(12'h000, 0, d2);
      chk("resume", d2 > d1, 1);

      do_read(12'h010, 0, d);
      chk("unmapped_rd", d, 0);
      do_write(12'h018, 64'hDEAD_BEEF_0000_0000, 8'hFF, 0);
      do_write(12'h010, 64'h0, 8'hFF, 2);
      do_read(12'h000, 0, d);
      do_write(12'h008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
      do_read(12'h008, 0, d);
      chk("ctrl_bit0", d, 1);

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 3);
         repeat ($urandom_range(0, 3)) tick();
         case (op)
            0, 1: do_read(12'($urandom_range(0, 3)) << 3,
                          $urandom_range(0, 3), d);
            2: do_write(12'($urandom_range(0, 3)) << 3,
                        {$urandom, $urandom}, 8'($urandom),
                        $urandom_range(0, 3));
            default: do_write(12'h008, 64'($urandom_range(0, 3) != 0),
                              8'($urandom) | 8'h01,
                              $urandom_range(0, 2));
         endcase
         chk("rnd_cnt", cnt, m_now());
      end

      rd_start(12'h000, ed, er, hs);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      m_reset();
      chk("rst_mid_rvalid", rvalid, 0);
      chk("rst_mid_cnt", cnt, 0);
      rready = 1'b1;
      repeat (3) tick();
      chk("rst_no_beat", rvalid, 0);
      chk("rst_cnt3", cnt, m_now());
      rready = 1'b0;

      wr_start(12'h000, 64'h55, 8'hFF);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      m_reset();
      chk("rst_mid_bvalid", bvalid, 0);
      repeat (2) tick();
      do_read(12'h000, 0, d);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
